// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad password entry block: key codes,
// FSM state encoding and the default digit width.
package keypad_pkg;

  localparam int DIGIT_W_DEFAULT = 4;
  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [3:0] KEY_BKSP = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_ENT  = 4'hE;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_READY   = 2'd2
  } state_t;

endpackage

// File: rtl/keypad_password_entry_if.sv
// Keypad / password bus between the keypad front end and the parking
// controller. master = keypad side driver, slave = the entry block.
interface keypad_password_entry_if #(
  parameter int DIGIT_W = 4
) ();

  logic               Fs;
  logic               key_valid;
  logic [DIGIT_W-1:0] key_code;
  logic [DIGIT_W-1:0] P4;
  logic [DIGIT_W-1:0] P3;
  logic [DIGIT_W-1:0] P2;
  logic [DIGIT_W-1:0] P1;
  logic               pw_valid;
  logic [2:0]         digit_cnt;
  logic               busy;
  logic               entry_err;
  logic               timeout;

  modport master (
    output Fs, key_valid, key_code,
    input  P4, P3, P2, P1, pw_valid, digit_cnt, busy, entry_err, timeout
  );

  modport slave (
    input  Fs, key_valid, key_code,
    output P4, P3, P2, P1, pw_valid, digit_cnt, busy, entry_err, timeout
  );

endinterface

// File: rtl/keypad_password_entry_timer.sv
// Inactivity timer for the keypad entry: counts idle cycles while run is
// high, restarts on kick, and raises expire on the last idle cycle.
module keypad_inactivity_timer #(
  parameter int TO_W           = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic kick,
  output logic expire
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_count;
  logic            w_expire;

  assign w_expire = run && !kick && (r_count == TO_LAST);
  assign expire   = w_expire;

  // Idle counter: held at zero when not running, restarted by a key or expiry.
  always_ff @(posedge clk) begin
    if (reset || !run || kick || w_expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_password_entry.sv
// Keypad password entry: collects a 4-digit code while a car is at the
// front sensor and presents it on P4..P1 with pw_valid after ENTER.
// Optional inactivity timeout enabled by defining KEYPAD_TIMEOUT_EN.
module keypad_password_entry
  import keypad_pkg::*;
#(
  parameter int DIGIT_W        = DIGIT_W_DEFAULT,
  parameter int TO_W           = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  keypad_password_entry_if.slave  bus
);

  state_t             r_state;
  state_t             w_next;

  logic [DIGIT_W-1:0] r_buf     [NUM_DIGITS];
  logic [DIGIT_W-1:0] w_buf_nxt [NUM_DIGITS];
  logic [DIGIT_W-1:0] r_p       [NUM_DIGITS];
  logic [2:0]         r_cnt;
  logic [2:0]         w_cnt_nxt;
  logic [2:0]         w_cnt_dec;
  logic               r_pw_valid;
  logic               r_busy;
  logic               r_err;
  logic               r_to;
  logic               w_pw_nxt;
  logic               w_err_nxt;
  logic               w_to_nxt;
  logic               w_expire;
  logic               w_is_digit;
  logic               w_full;

  assign w_is_digit = (bus.key_code <= DIGIT_W'(KEY_MAX_DIGIT));
  assign w_full     = (r_cnt == 3'd4);
  assign w_cnt_dec  = r_cnt - 3'd1;

`ifdef KEYPAD_TIMEOUT_EN
  keypad_inactivity_timer #(
    .TO_W           (TO_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (r_state == ST_COLLECT),
    .kick   (bus.key_valid),
    .expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; losing the front sensor overrides every key.
  always_comb begin
    w_next = r_state;
    if (!bus.Fs) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_next = ST_COLLECT;
        ST_COLLECT: if (bus.key_valid && bus.key_code == DIGIT_W'(KEY_ENT) && w_full)
                      w_next = ST_READY;
        ST_READY:   if (bus.key_valid && bus.key_code == DIGIT_W'(KEY_CLR))
                      w_next = ST_COLLECT;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // Buffer, count and pulse next values for the current state and key.
  always_comb begin
    w_buf_nxt = r_buf;
    w_cnt_nxt = r_cnt;
    w_err_nxt = 1'b0;
    w_to_nxt  = 1'b0;
    if (!bus.Fs || r_state == ST_IDLE) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) w_buf_nxt[i] = '0;
      w_cnt_nxt = '0;
    end else if (r_state == ST_COLLECT) begin
      if (w_expire) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) w_buf_nxt[i] = '0;
        w_cnt_nxt = '0;
        w_to_nxt  = 1'b1;
      end else if (bus.key_valid) begin
        if (w_is_digit) begin
          if (!w_full) begin
            w_buf_nxt[r_cnt[1:0]] = bus.key_code;
            w_cnt_nxt             = r_cnt + 3'd1;
          end
        end else if (bus.key_code == DIGIT_W'(KEY_BKSP)) begin
          if (r_cnt != 3'd0) begin
            w_buf_nxt[w_cnt_dec[1:0]] = '0;
            w_cnt_nxt                 = w_cnt_dec;
          end
        end else if (bus.key_code == DIGIT_W'(KEY_CLR)) begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) w_buf_nxt[i] = '0;
          w_cnt_nxt = '0;
        end else if (bus.key_code == DIGIT_W'(KEY_ENT)) begin
          w_err_nxt = !w_full;
        end
      end
    end else if (r_state == ST_READY) begin
      if (bus.key_valid && bus.key_code == DIGIT_W'(KEY_CLR)) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) w_buf_nxt[i] = '0;
        w_cnt_nxt = '0;
      end
    end
  end

  // The password is presented only while READY persists, so pw_valid
  // trails the ENTER key by one register stage and drops on leaving READY.
  assign w_pw_nxt = (r_state == ST_READY) && (w_next == ST_READY);

  // Buffer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        r_buf[i] <= '0;
        r_p[i]   <= '0;
      end
      r_cnt      <= '0;
      r_pw_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_to       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        r_buf[i] <= w_buf_nxt[i];
        r_p[i]   <= w_pw_nxt ? r_buf[i] : '0;
      end
      r_cnt      <= w_cnt_nxt;
      r_pw_valid <= w_pw_nxt;
      r_busy     <= (w_next != ST_IDLE);
      r_err      <= w_err_nxt;
      r_to       <= w_to_nxt;
    end
  end

  assign bus.P4        = r_p[0];
  assign bus.P3        = r_p[1];
  assign bus.P2        = r_p[2];
  assign bus.P1        = r_p[3];
  assign bus.pw_valid  = r_pw_valid;
  assign bus.digit_cnt = r_cnt;
  assign bus.busy      = r_busy;
  assign bus.entry_err = r_err;
  assign bus.timeout   = r_to;

endmodule

// File: tb/tb_keypad_password_entry.sv
// Directed self-checking bench for keypad_password_entry.
// Covers both builds (KEYPAD_TIMEOUT_EN defined or not).
module tb_keypad_password_entry;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   to_pulses;

  keypad_password_entry_if #(.DIGIT_W(4)) bus ();

  keypad_password_entry #(
    .DIGIT_W        (4),
    .TO_W           (16),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic chk_pw(input string tag, input logic [15:0] exp);
    chk(tag, {bus.P4, bus.P3, bus.P2, bus.P1}, exp);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    to_pulses = 0;
    reset = 1'b1;
    bus.Fs = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code = 4'h0;
    tick(2);

    // Reset state
    chk("rst_pw_valid", bus.pw_valid, 1'b0);
    chk("rst_cnt", bus.digit_cnt, 3'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk_pw("rst_p", 16'h0000);
    chk("rst_err", bus.entry_err, 1'b0);
    chk("rst_to", bus.timeout, 1'b0);
    reset = 1'b0;

    // Keys ignored in IDLE without a car
    press(4'h5);
    chk("idle_cnt", bus.digit_cnt, 3'd0);
    chk("idle_busy", bus.busy, 1'b0);

    // Test 1: full entry
    bus.Fs = 1'b1;
    tick(1);
    chk("arm_busy", bus.busy, 1'b1);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("t1_cnt", bus.digit_cnt, 3'd4);
    press(4'hE);
    chk("t1_pw_lag", bus.pw_valid, 1'b0);
    tick(1);
    chk("t1_pw_valid", bus.pw_valid, 1'b1);
    chk_pw("t1_p", 16'h1234);
    chk("t1_cnt4", bus.digit_cnt, 3'd4);
    press(4'hC);
    chk("t1_clr_pw", bus.pw_valid, 1'b0);
    chk("t1_clr_cnt", bus.digit_cnt, 3'd0);
    chk_pw("t1_clr_p", 16'h0000);

    // Test 2: short entry
    press(4'h1); press(4'h2); press(4'hE);
    chk("t2_err", bus.entry_err, 1'b1);
    chk("t2_cnt", bus.digit_cnt, 3'd2);
    chk("t2_pw", bus.pw_valid, 1'b0);
    chk_pw("t2_p", 16'h0000);
    tick(1);
    chk("t2_err_pulse", bus.entry_err, 1'b0);
    chk("t2_pw_after", bus.pw_valid, 1'b0);
    press(4'hC);
    chk("t2_clr_cnt", bus.digit_cnt, 3'd0);
    press(4'hB);
    chk("bksp_at_zero", bus.digit_cnt, 3'd0);

    // Test 3: backspace, ignored codes, overflow digit
    press(4'h1); press(4'h2); press(4'h9); press(4'hB);
    chk("t3_bksp_cnt", bus.digit_cnt, 3'd2);
    press(4'hA); press(4'hD); press(4'hF);
    chk("t3_ign_cnt", bus.digit_cnt, 3'd2);
    press(4'h3); press(4'h4); press(4'h5);
    chk("t3_full_cnt", bus.digit_cnt, 3'd4);
    press(4'hE);
    tick(1);
    chk("t3_pw_valid", bus.pw_valid, 1'b1);
    chk_pw("t3_p", 16'h1234);
    press(4'h7); press(4'hB);
    chk_pw("t3_ready_hold", 16'h1234);
    chk("t3_ready_cnt", bus.digit_cnt, 3'd4);
    chk("t3_ready_pw", bus.pw_valid, 1'b1);

    // Test 4: Fs drop together with a key in READY
    @(negedge clk);
    bus.Fs = 1'b0;
    bus.key_valid = 1'b1;
    bus.key_code = 4'h7;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code = 4'h0;
    chk("t4_busy", bus.busy, 1'b0);
    chk("t4_pw", bus.pw_valid, 1'b0);
    chk_pw("t4_p", 16'h0000);
    chk("t4_cnt", bus.digit_cnt, 3'd0);
    bus.Fs = 1'b1;
    tick(1);
    chk("t4_rearm_busy", bus.busy, 1'b1);
    chk("t4_rearm_cnt", bus.digit_cnt, 3'd0);

    // Test 5: inactivity timeout (20 cycles)
    press(4'h1);
    chk("t5_cnt1", bus.digit_cnt, 3'd1);
    tick(19);
    chk("t5_no_early", bus.timeout, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.timeout === 1'b1) to_pulses++;
    end
`ifdef KEYPAD_TIMEOUT_EN
    chk("t5_pulses", to_pulses, 1);
    chk("t5_cnt", bus.digit_cnt, 3'd0);
`else
    chk("t5_pulses", to_pulses, 0);
    chk("t5_cnt", bus.digit_cnt, 3'd1);
`endif
    chk("t5_busy", bus.busy, 1'b1);

    // Test 6: reset mid-entry
    press(4'hC);
    press(4'h1); press(4'h2); press(4'h3);
    chk("t6_cnt3", bus.digit_cnt, 3'd3);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code = 4'hE;
    reset = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code = 4'h0;
    chk("t6_cnt", bus.digit_cnt, 3'd0);
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_pw", bus.pw_valid, 1'b0);
    chk("t6_err", bus.entry_err, 1'b0);
    chk("t6_to", bus.timeout, 1'b0);
    chk_pw("t6_p", 16'h0000);
    reset = 1'b0;
    tick(1);
    chk("t6_rearm_busy", bus.busy, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
